// File: rtl/muldiv_iter.sv
// muldiv_iter -- iterative RV32M-style multiply/divide unit.
//
// Multiplies with a radix-2 shift-add loop on 2*WIDTH-bit magnitudes and
// divides with a restoring loop on WIDTH-bit magnitudes. Signs are stripped
// at accept time and re-applied in the final RUN cycle. Looped operations
// present a result WIDTH+1 cycles after the accept edge; divide-by-zero,
// signed overflow and (when division is compiled out) divide ops finish
// one cycle after accept.
//
// Build option:
//   SAIL_MULDIV_DIV_EN  when defined, ops 4-7 (DIV/DIVU/REM/REMU) are
//                       implemented; when undefined no divider datapath
//                       exists and ops 4-7 complete with result 0, err 1.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   in_valid   request presented
//   in_ready   request accepted this cycle (high only in IDLE)
//   op[2:0]    RV32M funct3 (0 MUL .. 7 REMU)
//   a, b       operands (rs1, rs2), captured at the accept edge
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result
//   result     operation result, stable while out_valid
//   err        divide-by-zero or disabled op, valid with out_valid

module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 2 * WIDTH;
  // Counter value of the final RUN cycle: WIDTH iterations precede it.
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [2:0]      op_reg, op_next;
  logic            neg_reg, neg_next;        // product / quotient negative
  logic [DW-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [DW-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic            err_reg, err_next;

  // Operand sign handling for the incoming request.
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [DW-1:0]    prod_final;

  assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign a_neg    = a_signed && a[WIDTH-1];
  assign b_neg    = b_signed && b[WIDTH-1];
  // Negating the most-negative value yields 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign prod_final = neg_reg ? -acc_reg : acc_reg;

`ifdef SAIL_MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] dividend_reg, dividend_next;  // shifts out dividend, shifts in quotient
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             rem_neg_reg, rem_neg_next;
  logic             bypass_reg, bypass_next;

  logic [WIDTH:0]   div_shifted;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, quo_final, rem_final;
  logic             div_zero, div_ovf;

  assign div_zero    = (b == '0);
  assign div_ovf     = a_signed && (a == MOST_NEG) && (b == '1);
  assign div_shifted = {rem_reg, dividend_reg[WIDTH-1]};
  assign div_ge      = (div_shifted >= {1'b0, divisor_reg});
  // When the trial succeeds the true difference is below the divisor, so
  // the low WIDTH bits of the modular subtraction are exact.
  assign div_diff    = div_shifted[WIDTH-1:0] - divisor_reg;
  assign quo_final   = neg_reg ? -dividend_reg : dividend_reg;
  assign rem_final   = rem_neg_reg ? -rem_reg : rem_reg;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign err       = err_reg;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    neg_next    = neg_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    err_next    = err_reg;
`ifdef SAIL_MULDIV_DIV_EN
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    rem_next      = rem_reg;
    rem_neg_next  = rem_neg_reg;
    bypass_next   = bypass_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next    = op;
          count_next = '0;
          neg_next   = a_neg ^ b_neg;
          if (!op[2]) begin
            state_next  = MUL_RUN;
            mcand_next  = {{WIDTH{1'b0}}, a_mag};
            mplier_next = b_mag;
            acc_next    = '0;
          end else begin
            state_next = DIV_RUN;
`ifdef SAIL_MULDIV_DIV_EN
            dividend_next = a_mag;
            divisor_next  = b_mag;
            rem_next      = '0;
            rem_neg_next  = a_neg;
            bypass_next   = div_zero || div_ovf;
            // Special-case results are loaded now; the single DIV_RUN
            // cycle that follows only moves to DONE.
            if (div_zero) begin
              result_next = op[1] ? a : '1;
              err_next    = 1'b1;
            end else if (div_ovf) begin
              result_next = op[1] ? '0 : a;
              err_next    = 1'b0;
            end
`else
            result_next = '0;
            err_next    = 1'b1;
`endif
          end
        end
      end

      MUL_RUN: begin
        if (count_reg == LAST) begin
          result_next = (op_reg == 3'd0) ? prod_final[WIDTH-1:0] : prod_final[DW-1:WIDTH];
          err_next    = 1'b0;
          count_next  = '0;
          state_next  = DONE;
        end else begin
          if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
          end
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          count_next  = count_reg + CW'(1);
        end
      end

      DIV_RUN: begin
`ifdef SAIL_MULDIV_DIV_EN
        if (bypass_reg) begin
          count_next = '0;
          state_next = DONE;
        end else if (count_reg == LAST) begin
          result_next = op_reg[1] ? rem_final : quo_final;
          err_next    = 1'b0;
          count_next  = '0;
          state_next  = DONE;
        end else begin
          rem_next      = div_ge ? div_diff : div_shifted[WIDTH-1:0];
          dividend_next = {dividend_reg[WIDTH-2:0], div_ge};
          count_next    = count_reg + CW'(1);
        end
`else
        count_next = '0;
        state_next = DONE;
`endif
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
`ifdef SAIL_MULDIV_DIV_EN
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      rem_neg_reg  <= 1'b0;
      bypass_reg   <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      neg_reg    <= neg_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      err_reg    <= err_next;
`ifdef SAIL_MULDIV_DIV_EN
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      rem_reg      <= rem_next;
      rem_neg_reg  <= rem_neg_next;
      bypass_reg   <= bypass_next;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Testbench for muldiv_iter (WIDTH=32). Expectations come from a 64-bit
// arithmetic reference model; division expectations follow the
// SAIL_MULDIV_DIV_EN build option.

module tb_muldiv_iter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;

  int checks   = 0;
  int failures = 0;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {err, result}.
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy, zx, zy, p;
    logic [31:0] r;
    logic e;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    zx = {32'b0, x};
    zy = {32'b0, y};
    r = '0;
    e = 1'b0;
    p = '0;
    case (o)
      3'd0: begin p = zx * zy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * zy; r = p[63:32]; end
      3'd3: begin p = zx * zy; r = p[63:32]; end
      3'd4: if (y == 0) begin r = '1; e = 1'b1; end else begin p = sx / sy; r = p[31:0]; end
      3'd5: if (y == 0) begin r = '1; e = 1'b1; end else r = x / y;
      3'd6: if (y == 0) begin r = x; e = 1'b1; end else begin p = sx % sy; r = p[31:0]; end
      default: if (y == 0) begin r = x; e = 1'b1; end else r = x % y;
    endcase
`ifndef SAIL_MULDIV_DIV_EN
    if (o[2]) begin
      r = '0;
      e = 1'b1;
    end
`endif
    return {e, r};
  endfunction

  function automatic int model_latency(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
    if (!o[2]) return 33;
`ifdef SAIL_MULDIV_DIV_EN
    if (y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Presents one request (called #1 after a rising edge with the DUT idle),
  // scrambles the operands after accept, waits for out_valid with a bound,
  // samples the result and completes the handshake. lat = -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic e, output int lat);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    r = result;
    e = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    $display("reset: out_valid=%b result=%h err=%b in_ready=%b", out_valid, result, err, in_ready);
  endtask

  task automatic test_directed();
    logic [2:0]  ops [10];
    logic [31:0] xs  [10];
    logic [31:0] ys  [10];
    logic [31:0] r;
    logic        e;
    int          lat;
    logic [32:0] exp;
    int          exp_lat;
    int          count;
    ops[0] = 3'd0; xs[0] = 32'd7;          ys[0] = 32'hFFFF_FFFD;
    ops[1] = 3'd3; xs[1] = 32'hFFFF_FFFF;  ys[1] = 32'hFFFF_FFFF;
    ops[2] = 3'd2; xs[2] = 32'hFFFF_FFFF;  ys[2] = 32'd2;
    ops[3] = 3'd4; xs[3] = 32'h8000_0000;  ys[3] = 32'hFFFF_FFFF;
    ops[4] = 3'd6; xs[4] = 32'h8000_0000;  ys[4] = 32'hFFFF_FFFF;
    ops[5] = 3'd4; xs[5] = 32'hFFFF_FFF9;  ys[5] = 32'd2;
    ops[6] = 3'd6; xs[6] = 32'hFFFF_FFF9;  ys[6] = 32'd2;
    ops[7] = 3'd5; xs[7] = 32'd100;        ys[7] = 32'd0;
    ops[8] = 3'd7; xs[8] = 32'd100;        ys[8] = 32'd0;
    ops[9] = 3'd1; xs[9] = 32'h8000_0000;  ys[9] = 32'h8000_0000;
`ifdef SAIL_MULDIV_DIV_EN
    count = 10;
`else
    count = 3;
`endif
    for (int i = 0; i < count; i++) begin
      run_op(ops[i], xs[i], ys[i], r, e, lat);
      exp = model(ops[i], xs[i], ys[i]);
      exp_lat = model_latency(ops[i], xs[i], ys[i]);
      checks++;
      if (r !== exp[31:0]) begin failures++; $display("FAIL directed_result[%0d] got=%h want=%h", i, r, exp[31:0]); end
      checks++;
      if (e !== exp[32]) begin failures++; $display("FAIL directed_err[%0d] got=%b want=%b", i, e, exp[32]); end
      checks++;
      if (lat != exp_lat) begin failures++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, exp_lat); end
      $display("directed op=%0d a=%h b=%h -> result=%h err=%b lat=%0d", ops[i], xs[i], ys[i], r, e, lat);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, r;
    logic        e;
    int          lat;
    logic [32:0] exp;
    int          exp_lat;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      x = pick_operand();
      y = pick_operand();
      run_op(o, x, y, r, e, lat);
      exp = model(o, x, y);
      exp_lat = model_latency(o, x, y);
      checks++;
      if (r !== exp[31:0] || e !== exp[32] || lat != exp_lat) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h/%b/%0d want=%h/%b/%0d",
                 i, o, x, y, r, e, lat, exp[31:0], exp[32], exp_lat);
      end
      $display("random op=%0d a=%h b=%h -> result=%h err=%b lat=%0d", o, x, y, r, e, lat);
    end
  endtask

  task automatic test_hold();
    logic [31:0] x, y, held_r;
    logic        held_e;
    logic [32:0] exp;
    int          lat;
    x = $urandom; y = $urandom;
    exp = model(3'd1, x, y);
    op = 3'd1; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    held_r = result;
    held_e = err;
    checks++;
    if (lat != 33 || held_r !== exp[31:0]) begin
      failures++;
      $display("FAIL hold_result got=%h lat=%0d want=%h lat=33", held_r, lat, exp[31:0]);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      op = 3'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== held_r || err !== held_e || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d] got v=%b r=%h e=%b rdy=%b want v=1 r=%h e=%b rdy=0",
                 c, out_valid, result, err, in_ready, held_r, held_e);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_no_stale_accept got rdy=%b want=1", in_ready); end
    $display("hold: result=%h held 5 cycles, released", held_r);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic        e;
    int          lat;
    int          seen;
    op = 3'd0; a = $urandom; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (result !== 32'h0 || err !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got r=%h e=%b v=%b want r=0 e=0 v=0", result, err, out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_no_output got=%0d valid cycles want=0", seen); end
    run_op(3'd0, 32'd3, 32'd5, r, e, lat);
    checks++;
    if (r !== 32'd15 || e !== 1'b0 || lat != 33) begin
      failures++;
      $display("FAIL midreset_followup got=%h/%b/%0d want=0000000f/0/33", r, e, lat);
    end
    $display("reset_mid: follow-up MUL 3x5 -> result=%h lat=%0d", r, lat);
  endtask

  task automatic test_back_to_back();
    logic [31:0] x2, y2;
    logic [32:0] exp;
    int          lat;
    op = 3'd0; a = $urandom; b = $urandom; in_valid = 1'b1;
    exp = model(3'd0, a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    checks++;
    if (result !== exp[31:0] || lat != 33) begin
      failures++;
      $display("FAIL b2b_first got=%h lat=%0d want=%h lat=33", result, lat, exp[31:0]);
    end
    x2 = $urandom; y2 = $urandom;
    op = 3'd3; a = x2; b = y2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_not_accepted got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got rdy=%b want=0", in_ready); end
    exp = model(3'd3, x2, y2);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    checks++;
    if (result !== exp[31:0] || lat != 33) begin
      failures++;
      $display("FAIL b2b_second got=%h lat=%0d want=%h lat=33", result, lat, exp[31:0]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("back_to_back: second MULHU a=%h b=%h -> result=%h lat=%0d", x2, y2, result, lat);
  endtask

`ifndef SAIL_MULDIV_DIV_EN
  task automatic test_no_div();
    logic [31:0] r;
    logic        e;
    int          lat;
    run_op(3'd4, 32'd10, 32'd2, r, e, lat);
    checks++;
    if (r !== 32'd0 || e !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL nodiv_div got=%h/%b/%0d want=00000000/1/1", r, e, lat);
    end
    $display("no_div: DIV 10/2 -> result=%h err=%b lat=%0d", r, e, lat);
    run_op(3'd0, 32'd6, 32'd7, r, e, lat);
    checks++;
    if (r !== 32'd42 || e !== 1'b0 || lat != 33) begin
      failures++;
      $display("FAIL nodiv_mul got=%h/%b/%0d want=0000002a/0/33", r, e, lat);
    end
    $display("no_div: MUL 6x7 -> result=%h err=%b lat=%0d", r, e, lat);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifndef SAIL_MULDIV_DIV_EN
    test_no_div();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are even numbers from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a request is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port op, input, 3 bits, carrying RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each, carrying the operands (a = rs1, b = rs2).
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-010 The block SHALL have port result, output, WIDTH bits, carrying the operation result.
REQ-011 The block SHALL have port err, output, 1 bit, valid with out_valid, flagging divide-by-zero or a disabled operation.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, MUL_RUN, DIV_RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where in_valid and in_ready are both 1, and op/a/b are captured at that edge.
REQ-014 MUL* requests SHALL enter MUL_RUN and perform radix-2 shift-add on 2*WIDTH-bit magnitudes for exactly WIDTH cycles, then enter DONE.
REQ-015 Signedness SHALL be per RISC-V: MULH signed x signed; MULHSU signed a, unsigned b; MULHU unsigned; MUL returns the low WIDTH bits; the MULH* variants return the high WIDTH bits of the exact 2*WIDTH product.
REQ-016 DIV/REM requests SHALL enter DIV_RUN and perform restoring division on magnitudes for exactly WIDTH cycles; signs are fixed after the loop (quotient negative iff operand signs differ, remainder takes the sign of a).
REQ-017 When b == 0, the block SHALL bypass the loop and enter DONE at the next edge with quotient all-ones, remainder = a and err = 1.
REQ-018 For signed overflow (a = most-negative, b = all-ones) with DIV/REM, the block SHALL bypass the loop and enter DONE at the next edge with quotient = a, remainder = 0 and err = 0.
REQ-019 Latency SHALL be: out_valid high WIDTH+1 cycles after the accept edge for looped operations, and 1 cycle after it for bypassed operations.
REQ-020 In DONE, out_valid SHALL be 1 and result/err SHALL hold stable until an edge with out_ready = 1, which returns the FSM to IDLE; a new request is not accepted in that same cycle (no back-to-back accept).
REQ-021 in_valid SHALL be ignored outside IDLE, and operand changes after the accept edge SHALL NOT affect the result.
REQ-022 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL wrap to 0 on leaving the RUN states.

Reset
REQ-023 rst = 1 at a rising edge SHALL force IDLE, out_valid = 0, result = 0, err = 0 and counter = 0, including mid-operation; the in-flight request is discarded and nothing is output for it.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-025 The macro SAIL_MULDIV_DIV_EN SHALL control division: when defined, DIV/DIVU/REM/REMU behave per REQ-016 to REQ-018.
REQ-026 When SAIL_MULDIV_DIV_EN is undefined, no divider logic SHALL be synthesised; ops 4-7 go to DONE at the next edge with result = 0 and err = 1, and MUL* behaviour is unchanged.

Verification (WIDTH=32, SAIL_MULDIV_DIV_EN defined unless noted)
REQ-027 The bench SHALL cover: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, err 0, out_valid exactly 33 cycles after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-028 The bench SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, err 0, out_valid 1 cycle after accept; REM same operands -> 0; DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF.
REQ-029 The bench SHALL cover: DIVU 100 / 0 -> 0xFFFFFFFF, err 1, latency 1; REMU 100 / 0 -> 100, err 1.
REQ-030 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and result stable throughout, in_ready 0, in_valid pulses ignored; then out_ready = 1 -> IDLE next cycle.
REQ-031 The bench SHALL cover: rst asserted on cycle 10 of a MUL -> out_valid stays 0, in_ready 1 after release; a following MUL 3 x 5 -> 15 at correct latency.
REQ-032 The bench SHALL cover, with SAIL_MULDIV_DIV_EN undefined: DIV 10 / 2 -> result 0, err 1, latency 1; MUL 6 x 7 -> 42.
